// File: rtl/auth_pkg.sv
// Shared definitions for the authentication message receiver: message type
// codes, header field offsets, protocol version and FSM state encoding.
package auth_pkg;

  localparam logic [7:0] MSG_DIGESTS         = 8'h01;
  localparam logic [7:0] MSG_CERTIFICATE     = 8'h02;
  localparam logic [7:0] MSG_CHALLENGE_AUTH  = 8'h03;
  localparam logic [7:0] MSG_ERROR           = 8'h7F;
  localparam logic [7:0] MSG_GET_DIGESTS     = 8'h81;
  localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] MSG_CHALLENGE       = 8'h83;

  localparam int HDR_VER_LSB  = 24;
  localparam int HDR_TYPE_LSB = 16;

  localparam logic [7:0] PROTOCOL_VERSION_DEF = 8'h01;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_CAPTURE = 6'b000010,
    S_CHECK   = 6'b000100,
    S_PUSH    = 6'b001000,
    S_DROP    = 6'b010000,
    S_ACK     = 6'b100000
  } state_e;

  function automatic logic is_auth_type(input logic [7:0] msg_type);
    case (msg_type)
      MSG_DIGESTS, MSG_CERTIFICATE, MSG_CHALLENGE_AUTH, MSG_ERROR,
      MSG_GET_DIGESTS, MSG_GET_CERTIFICATE, MSG_CHALLENGE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/auth_rx_fifo.sv
// Synchronous FIFO for accepted messages; head word is read combinationally
// from the read pointer so it stays stable until popped.
module auth_rx_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q,
  // so stale words are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/auth_msg_receiver.sv
// Far-end sink for authentication messages: 4-phase valid/Ack capture, header
// checks, FIFO buffering. Optional counters enabled by AUTH_RX_STATS_EN.
module auth_msg_receiver
  import auth_pkg::*;
#(
  parameter int         HEADER_W         = 32,
  parameter int         PAYLOAD_W        = 64,
  parameter int         MSG_LEN          = 128,
  parameter int         DEPTH            = 4,
  parameter logic [7:0] PROTOCOL_VERSION = PROTOCOL_VERSION_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MSG_LEN-1:0]   auth_msg_in,
  input  logic                 auth_msg_valid,
  input  logic                 usb_mode,
  output logic                 Ack_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [7:0]           rx_msg_type,
  output logic [HEADER_W-1:0]  rx_header,
  output logic [PAYLOAD_W-1:0] rx_payload,
  output logic                 rx_usb,
  output logic                 Error_bad_msg,
  output logic                 fifo_full
`ifdef AUTH_RX_STATS_EN
  ,
  output logic [7:0]           rx_accept_cnt,
  output logic [7:0]           rx_drop_cnt
`endif
);

  // Everything below bmRequestType/bRequest; the raw format fits inside it.
  localparam int          BODY_W   = HEADER_W + 16 + PAYLOAD_W;
  localparam int          ENTRY_W  = HEADER_W + PAYLOAD_W + 1;
  localparam logic [15:0] WLEN_MIN = 16'd4;
  localparam logic [15:0] WLEN_MAX = 16'((HEADER_W + PAYLOAD_W) / 8);

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  state_e               state_q;
  logic [BODY_W-1:0]    body_q;
  logic                 usb_q;
  logic [HEADER_W-1:0]  hdr_q, hdr_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic [15:0]          wlen_q, wlen_d;
  logic                 ack_q, err_q, push_q;
  logic                 check_pass;
  logic                 fifo_empty, fifo_full_w;
  logic [ENTRY_W-1:0]   fifo_rdata, head;
  logic                 unused_framing;

  assign unused_framing = ^auth_msg_in[MSG_LEN-1:BODY_W];

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // NOTE: every variable gets a default before the branch so no latch forms.
  always_comb begin
    hdr_d  = body_q[PAYLOAD_W +: HEADER_W];
    wlen_d = '0;
    if (usb_q) begin
      hdr_d  = body_q[PAYLOAD_W + 16 +: HEADER_W];
      wlen_d = body_q[PAYLOAD_W +: 16];
    end
  end
  assign pay_d = body_q[PAYLOAD_W-1:0];

  assign check_pass = (hdr_q[HDR_VER_LSB +: 8] == PROTOCOL_VERSION)
                   && is_auth_type(hdr_q[HDR_TYPE_LSB +: 8])
                   && (!usb_q || (wlen_q >= WLEN_MIN && wlen_q <= WLEN_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      body_q  <= '0;
      usb_q   <= 1'b0;
      hdr_q   <= '0;
      pay_q   <= '0;
      wlen_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= (state_q == S_PUSH);
      err_q  <= (state_q == S_DROP);
      // Ack is guaranteed at least one cycle before it can follow valid low.
      ack_q  <= (state_q == S_ACK) && !(ack_q && !auth_msg_valid);
      case (state_q)
        S_IDLE: begin
          if (auth_msg_valid && !fifo_full_w) begin
            body_q  <= auth_msg_in[BODY_W-1:0];
            usb_q   <= usb_mode;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          hdr_q   <= hdr_d;
          pay_q   <= pay_d;
          wlen_q  <= wlen_d;
          state_q <= S_CHECK;
        end
        S_CHECK:        state_q <= check_pass ? S_PUSH : S_DROP;
        S_PUSH, S_DROP: state_q <= S_ACK;
        S_ACK: begin
          if (ack_q && !auth_msg_valid) state_q <= S_IDLE;
        end
        default:        state_q <= S_IDLE;
      endcase
    end
  end

  auth_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .pop_i   (rx_ready),
    .wdata_i ({usb_q, hdr_q, pay_q}),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full_w)
  );

  // Head fields read as zero while empty so outputs are clean after reset.
  assign head          = fifo_empty ? '0 : fifo_rdata;
  assign rx_valid      = !fifo_empty;
  assign rx_usb        = head[ENTRY_W-1];
  assign rx_header     = head[PAYLOAD_W +: HEADER_W];
  assign rx_payload    = head[PAYLOAD_W-1:0];
  assign rx_msg_type   = rx_header[HDR_TYPE_LSB +: 8];
  assign fifo_full     = fifo_full_w;
  assign Ack_out       = ack_q;
  assign Error_bad_msg = err_q;

`ifdef AUTH_RX_STATS_EN
  logic [7:0] accept_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (state_q == S_PUSH && accept_cnt_q != 8'hFF) accept_cnt_q <= accept_cnt_q + 8'd1;
      if (state_q == S_DROP && drop_cnt_q != 8'hFF)   drop_cnt_q   <= drop_cnt_q + 8'd1;
    end
  end

  assign rx_accept_cnt = accept_cnt_q;
  assign rx_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_auth_msg_receiver.sv
// Self-checking bench for auth_msg_receiver: directed scenarios plus random
// messages checked against a rule-level acceptance model and an ordered queue.
`timescale 1ns/1ps
module tb_auth_msg_receiver;

  localparam int MAXW = 40;
  localparam logic [7:0] AUTH_TYPES [7] = '{8'h01, 8'h02, 8'h03, 8'h7F, 8'h81, 8'h82, 8'h83};

  typedef struct {
    logic [31:0] hdr;
    logic [63:0] pay;
    logic        usb;
  } ent_t;

  typedef struct {
    int         lat;
    int         errs;
    int         fall;
    logic       rxv_pre;
    logic       rxv;
    logic [7:0] typ;
    logic       usb;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] auth_msg_in;
  logic         auth_msg_valid;
  logic         usb_mode;
  logic         Ack_out;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   rx_msg_type;
  logic [31:0]  rx_header;
  logic [63:0]  rx_payload;
  logic         rx_usb;
  logic         Error_bad_msg;
  logic         fifo_full;
`ifdef AUTH_RX_STATS_EN
  logic [7:0]   rx_accept_cnt;
  logic [7:0]   rx_drop_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  auth_msg_receiver dut (
    .clk            (clk),
    .reset          (reset),
    .auth_msg_in    (auth_msg_in),
    .auth_msg_valid (auth_msg_valid),
    .usb_mode       (usb_mode),
    .Ack_out        (Ack_out),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_msg_type    (rx_msg_type),
    .rx_header      (rx_header),
    .rx_payload     (rx_payload),
    .rx_usb         (rx_usb),
    .Error_bad_msg  (Error_bad_msg),
    .fifo_full      (fifo_full)
`ifdef AUTH_RX_STATS_EN
    ,
    .rx_accept_cnt  (rx_accept_cnt),
    .rx_drop_cnt    (rx_drop_cnt)
`endif
  );

  function automatic logic [127:0] mk_usb(input logic [7:0] bm, input logic [7:0] br,
                                          input logic [31:0] hdr, input logic [15:0] wl,
                                          input logic [63:0] pay);
    return {bm, br, hdr, wl, pay};
  endfunction

  function automatic logic [127:0] mk_raw(input logic [31:0] hdr, input logic [63:0] pay);
    return {32'h0, hdr, pay};
  endfunction

  // Acceptance rules stated directly: version 1, known type, USB length 4..12 bytes.
  function automatic logic model_accepts(input logic [31:0] hdr, input logic usb, input logic [15:0] wl);
    logic type_ok;
    type_ok = 1'b0;
    for (int i = 0; i < 7; i++) if (hdr[23:16] == AUTH_TYPES[i]) type_ok = 1'b1;
    return (hdr[31:24] == 8'h01) && type_ok && (!usb || (wl >= 16'd4 && wl <= 16'd12));
  endfunction

  function automatic logic [31:0] rand_good_hdr();
    return {8'h01, AUTH_TYPES[$urandom_range(0, 6)], 16'($urandom)};
  endfunction

  // Presents one message under the 4-phase handshake; caller sits on a negedge.
  task automatic send(input logic [127:0] msg, input logic usb, output res_t r);
    r.lat = 0; r.errs = 0; r.fall = 0;
    r.rxv_pre = rx_valid; r.rxv = 1'b0; r.typ = '0; r.usb = 1'b0;
    auth_msg_in = msg; usb_mode = usb; auth_msg_valid = 1'b1;
    while (Ack_out !== 1'b1 && r.lat < MAXW) begin
      r.rxv_pre = rx_valid;
      @(negedge clk); r.lat++;
      if (Error_bad_msg === 1'b1) r.errs++;
    end
    r.rxv = rx_valid; r.typ = rx_msg_type; r.usb = rx_usb;
    auth_msg_valid = 1'b0;
    while (Ack_out !== 1'b0 && r.fall < MAXW) begin
      @(negedge clk); r.fall++;
      if (Error_bad_msg === 1'b1) r.errs++;
    end
  endtask

  task automatic drain_and_compare(input string name);
    ent_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_valid !== 1'b1 || rx_header !== e.hdr || rx_payload !== e.pay ||
          rx_usb !== e.usb || rx_msg_type !== e.hdr[23:16]) begin
        errors++;
        $display("FAIL %s head: got v=%b hdr=%h pay=%h usb=%b type=%h want v=1 hdr=%h pay=%h usb=%b type=%h",
                 name, rx_valid, rx_header, rx_payload, rx_usb, rx_msg_type, e.hdr, e.pay, e.usb, e.hdr[23:16]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL %s empty_after_drain: got rx_valid=%b want 0", name, rx_valid);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Ack_out, rx_valid, Error_bad_msg, fifo_full, rx_usb} !== 5'b0 ||
        rx_header !== 32'h0 || rx_payload !== 64'h0 || rx_msg_type !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b v=%b err=%b full=%b hdr=%h want all zero",
               Ack_out, rx_valid, Error_bad_msg, fifo_full, rx_header);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (Ack_out !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ack=%b v=%b want 0 0", Ack_out, rx_valid);
    end
  endtask

  task automatic test_usb_basic();
    res_t r;
    send(mk_usb(8'hA1, 8'h0D, 32'h01810000, 16'd4, 64'h0), 1'b1, r);
    checks++;
    if (r.lat != 5) begin errors++; $display("FAIL usb_ack_latency: got %0d want 5", r.lat); end
    checks++;
    if (r.rxv_pre !== 1'b0 || r.rxv !== 1'b1) begin
      errors++; $display("FAIL usb_rx_valid_edge: got pre=%b at=%b want 0 1", r.rxv_pre, r.rxv);
    end
    checks++;
    if (r.typ !== 8'h81 || r.usb !== 1'b1) begin
      errors++; $display("FAIL usb_head: got type=%h usb=%b want 81 1", r.typ, r.usb);
    end
    checks++;
    if (r.fall != 1 || r.errs != 0) begin
      errors++; $display("FAIL usb_ack_fall: got fall=%0d errs=%0d want 1 0", r.fall, r.errs);
    end
    exp_q.push_back('{hdr: 32'h01810000, pay: 64'h0, usb: 1'b1});
    drain_and_compare("usb_basic");
  endtask

  task automatic test_non_usb();
    res_t r;
    send(mk_raw(32'h01030000, 64'hDEADBEEF_CAFEF00D), 1'b0, r);
    checks++;
    if (r.lat != 5 || r.errs != 0 || r.rxv !== 1'b1 || r.usb !== 1'b0) begin
      errors++;
      $display("FAIL raw_accept: got lat=%0d errs=%0d v=%b usb=%b want 5 0 1 0", r.lat, r.errs, r.rxv, r.usb);
    end
    exp_q.push_back('{hdr: 32'h01030000, pay: 64'hDEADBEEF_CAFEF00D, usb: 1'b0});
    drain_and_compare("non_usb");
  endtask

  task automatic test_bad();
    logic [127:0] msgs [3];
    logic         usbs [3];
    res_t         r;
    msgs[0] = mk_raw(32'h02810000, {$urandom, $urandom}); usbs[0] = 1'b0;
    msgs[1] = mk_usb(8'hA1, 8'h0D, 32'h01550000, 16'd4, 64'h1); usbs[1] = 1'b1;
    msgs[2] = mk_usb(8'hA1, 8'h0D, 32'h01810000, 16'd13, 64'h2); usbs[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(msgs[i], usbs[i], r);
      checks++;
      if (r.lat != 5 || r.errs != 1 || r.rxv !== 1'b0 || rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad_msg_%0d: got lat=%0d errs=%0d v=%b want 5 1 0", i, r.lat, r.errs, r.rxv);
      end
    end
  endtask

  task automatic test_wlen_bounds();
    logic [15:0] wls [4];
    logic [31:0] hdr;
    logic [63:0] pay;
    logic        acc;
    res_t        r;
    wls = '{16'd3, 16'd4, 16'd12, 16'd13};
    for (int i = 0; i < 4; i++) begin
      hdr = rand_good_hdr();
      pay = {$urandom, $urandom};
      acc = model_accepts(hdr, 1'b1, wls[i]);
      send(mk_usb(8'h21, 8'h09, hdr, wls[i], pay), 1'b1, r);
      checks++;
      if (r.lat != 5 || r.errs != (acc ? 0 : 1)) begin
        errors++;
        $display("FAIL wlen_%0d: got lat=%0d errs=%0d want 5 %0d", wls[i], r.lat, r.errs, acc ? 0 : 1);
      end
      if (acc) exp_q.push_back('{hdr: hdr, pay: pay, usb: 1'b1});
    end
    drain_and_compare("wlen_bounds");
  endtask

  task automatic test_backpressure();
    res_t        r;
    ent_t        e;
    logic [31:0] hdr;
    logic [63:0] pay;
    int          held_acks, lat;
    for (int i = 0; i < 4; i++) begin
      hdr = rand_good_hdr();
      pay = {$urandom, $urandom};
      send(mk_raw(hdr, pay), 1'b0, r);
      exp_q.push_back('{hdr: hdr, pay: pay, usb: 1'b0});
    end
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL fifo_full_set: got %b want 1", fifo_full); end
    hdr = rand_good_hdr();
    pay = {$urandom, $urandom};
    auth_msg_in = mk_raw(hdr, pay); usb_mode = 1'b0; auth_msg_valid = 1'b1;
    held_acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Ack_out !== 1'b0 || Error_bad_msg !== 1'b0) held_acks++;
    end
    checks++;
    if (held_acks != 0) begin errors++; $display("FAIL full_backpressure: got %0d ack cycles want 0", held_acks); end
    e = exp_q.pop_front();
    checks++;
    if (rx_header !== e.hdr || rx_payload !== e.pay) begin
      errors++; $display("FAIL full_head: got %h/%h want %h/%h", rx_header, rx_payload, e.hdr, e.pay);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    lat = 0;
    while (Ack_out !== 1'b1 && lat < MAXW) begin @(negedge clk); lat++; end
    checks++;
    if (lat >= MAXW) begin errors++; $display("FAIL fifth_ack_timeout: got %0d cycles want <%0d", lat, MAXW); end
    auth_msg_valid = 1'b0;
    lat = 0;
    while (Ack_out !== 1'b0 && lat < MAXW) begin @(negedge clk); lat++; end
    exp_q.push_back('{hdr: hdr, pay: pay, usb: 1'b0});
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL fifo_full_refill: got %b want 1", fifo_full); end
    drain_and_compare("backpressure");
  endtask

  task automatic test_reset_mid();
    res_t         r;
    logic [127:0] msg;
    logic [31:0]  hdr;
    logic [63:0]  pay;
    send(mk_raw(32'h01020000, 64'h1234), 1'b0, r);
    hdr = rand_good_hdr();
    pay = {$urandom, $urandom};
    msg = mk_usb(8'hA1, 8'h0D, hdr, 16'd8, pay);
    auth_msg_in = msg; usb_mode = 1'b1; auth_msg_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({Ack_out, rx_valid, Error_bad_msg, fifo_full, rx_usb} !== 5'b0 ||
        rx_header !== 32'h0 || rx_payload !== 64'h0 || rx_msg_type !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ack=%b v=%b err=%b full=%b hdr=%h want all zero",
               Ack_out, rx_valid, Error_bad_msg, fifo_full, rx_header);
    end
    auth_msg_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send(msg, 1'b1, r);
    checks++;
    if (r.lat != 5 || r.errs != 0 || r.rxv !== 1'b1) begin
      errors++; $display("FAIL reset_mid_resend: got lat=%0d errs=%0d v=%b want 5 0 1", r.lat, r.errs, r.rxv);
    end
    exp_q.push_back('{hdr: hdr, pay: pay, usb: 1'b1});
    drain_and_compare("reset_mid");
  endtask

  task automatic test_random();
    res_t        r;
    logic [31:0] hdr;
    logic [63:0] pay;
    logic [15:0] wl;
    logic        usb, acc;
    for (int i = 0; i < 24; i++) begin
      hdr = rand_good_hdr();
      if ($urandom_range(0, 3) == 0) hdr[31:24] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) hdr[23:16] = 8'($urandom);
      usb = 1'($urandom);
      wl  = 16'($urandom_range(0, 15));
      pay = {$urandom, $urandom};
      acc = model_accepts(hdr, usb, wl);
      send(usb ? mk_usb(8'($urandom), 8'($urandom), hdr, wl, pay) : mk_raw(hdr, pay), usb, r);
      checks++;
      if (r.lat != 5 || r.errs != (acc ? 0 : 1)) begin
        errors++;
        $display("FAIL random_%0d hdr=%h usb=%b wl=%0d: got lat=%0d errs=%0d want 5 %0d",
                 i, hdr, usb, wl, r.lat, r.errs, acc ? 0 : 1);
      end
      if (acc) exp_q.push_back('{hdr: hdr, pay: pay, usb: usb});
      checks++;
      if (fifo_full !== (exp_q.size() == 4)) begin
        errors++; $display("FAIL random_full_%0d: got %b want %b", i, fifo_full, exp_q.size() == 4);
      end
      if (exp_q.size() == 4) drain_and_compare("random");
    end
    drain_and_compare("random_tail");
  endtask

`ifdef AUTH_RX_STATS_EN
  task automatic test_stats();
    res_t r;
    apply_reset();
    checks++;
    if (rx_accept_cnt !== 8'h00 || rx_drop_cnt !== 8'h00) begin
      errors++; $display("FAIL stats_reset: got %h %h want 00 00", rx_accept_cnt, rx_drop_cnt);
    end
    rx_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      send(mk_raw(rand_good_hdr(), {$urandom, $urandom}), 1'b0, r);
      if (i == 254 || i == 300) begin
        checks++;
        if (rx_accept_cnt !== ((i > 255) ? 8'hFF : 8'(i))) begin
          errors++; $display("FAIL stats_accept_%0d: got %h want %h", i, rx_accept_cnt, (i > 255) ? 8'hFF : 8'(i));
        end
      end
    end
    send(mk_raw(32'h09010000, 64'h0), 1'b0, r);
    rx_ready = 1'b0;
    checks++;
    if (rx_drop_cnt !== 8'h01 || rx_accept_cnt !== 8'hFF) begin
      errors++; $display("FAIL stats_drop: got drop=%h acc=%h want 01 FF", rx_drop_cnt, rx_accept_cnt);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    auth_msg_in    = '0;
    auth_msg_valid = 1'b0;
    usb_mode       = 1'b0;
    rx_ready       = 1'b0;
    @(negedge clk);
    test_reset();
    test_usb_basic();
    test_non_usb();
    test_bad();
    test_wlen_bounds();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef AUTH_RX_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/auth_msg_receiver.md
Name: auth_msg_receiver

Overview:
- Far-end sink for authentication messages emitted by the authentication driver.
- Accepts one framed message (USB control framing or bare header+payload) under a 4-phase valid/Ack handshake.
- Parses and checks the header, buffers accepted messages in a small FIFO, and presents them to the local consumer with valid/ready.
- Returns the Ack the driver waits on in its ACK state.

Parameters:
HEADER_W, 32, header width in bits: ProtocolVersion[31:24], MessageType[23:16], Param1[15:8], Param2[7:0]
PAYLOAD_W, 64, payload width in bits
MSG_LEN, 128, input message width; must equal 8+8+HEADER_W+16+PAYLOAD_W
DEPTH, 4, FIFO entries; power of two, ≥2
PROTOCOL_VERSION, 8'h01, only accepted ProtocolVersion

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
auth_msg_in  in  MSG_LEN  message from driver
auth_msg_valid  in  1  driver's auth_msg_ready; message stable while high
usb_mode  in  1  1 = {bmRequestType,bRequest,header,wLength,payload}; 0 = {header,payload} right-aligned, upper bits zero
Ack_out  out  1  handshake back to driver Ack_in
rx_valid  out  1  FIFO head valid
rx_ready  in  1  consumer pops head when rx_valid & rx_ready
rx_msg_type  out  8  head MessageType
rx_header  out  HEADER_W  head header
rx_payload  out  PAYLOAD_W  head payload
rx_usb  out  1  head arrived with USB framing
Error_bad_msg  out  1  one-cycle pulse: version, type or length check failed
fifo_full  out  1  occupancy == DEPTH

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE. Reset mid-message drops it; the driver must re-present it.
- Registered outputs; async assert, synchronous release on posedge clk.
- States: IDLE, CAPTURE, CHECK, PUSH, DROP, ACK.
  - IDLE: auth_msg_valid & !fifo_full -> CAPTURE, latch auth_msg_in and usb_mode. When full, stay in IDLE with no Ack; this is backpressure.
  - CAPTURE: split fields per latched usb_mode -> CHECK.
  - CHECK: pass requires all of:
    - version == PROTOCOL_VERSION
    - type in {8'h01,8'h02,8'h03,8'h7F,8'h81,8'h82,8'h83}
    - if USB framing: 4 ≤ wLength ≤ (HEADER_W+PAYLOAD_W)/8
    Pass -> PUSH; fail -> DROP.
  - PUSH: one-cycle FIFO write -> ACK.
  - DROP: Error_bad_msg=1 for exactly this cycle; no write -> ACK.
  - ACK: Ack_out=1; held until auth_msg_valid==0, then Ack_out=0 and -> IDLE. If valid is already low on entry, Ack_out is high for one cycle.
- Latency: valid sampled at edge N -> Ack_out high after edge N+4. On a pass, rx_valid rises at the same edge (empty FIFO).
- FIFO:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leaves count unchanged. Pop while empty is ignored.
  - Head fields are driven from storage combinationally from the read pointer and are stable while rx_valid & !rx_ready.
- Fullness is checked only in IDLE. Pops can only free space, so PUSH never overflows.
- A new auth_msg_valid is not sampled until the FSM returns to IDLE.

Optional Feature:
AUTH_RX_STATS_EN
- Defined: adds outputs rx_accept_cnt[7:0] and rx_drop_cnt[7:0].
  - rx_accept_cnt increments in PUSH; rx_drop_cnt increments in DROP.
  - Both saturate at 8'hFF and clear on reset.
- Undefined: ports absent, no counter logic; all other behaviour identical.

Decomposition:
- Package auth_pkg holds:
  - message type codes: DIGESTS 8'h01, CERTIFICATE 8'h02, CHALLENGE_AUTH 8'h03, ERROR 8'h7F, GET_DIGESTS 8'h81, GET_CERTIFICATE 8'h82, CHALLENGE 8'h83
  - header field bit offsets
  - PROTOCOL_VERSION default
  - state encodings (one-hot)
- One sub-module, auth_rx_fifo: parameterized width/depth synchronous FIFO with push/pop/full/empty. Entry width is HEADER_W+PAYLOAD_W+1.

Test Plan:
1. USB msg {8'hA1, 8'h0D, 32'h01810000, 16'd4, 64'h0}, valid held high -> Ack_out high at edge N+4; rx_valid=1, rx_msg_type=8'h81, rx_usb=1; Ack_out falls one cycle after valid drops.
2. Non-USB {32'h01030000, 64'hDEADBEEF_CAFEF00D} -> rx_payload=64'hDEADBEEF_CAFEF00D, rx_usb=0, no error.
3. Version 8'h02, or type 8'h55, or USB wLength=16'd13 -> Error_bad_msg one-cycle pulse, Ack_out still asserted, rx_valid stays 0.
4. Four valid messages with rx_ready=0 -> fifo_full=1; fifth held without Ack until one pop, then accepted; pop order matches push order.
5. Reset driven low while in CHECK -> all outputs 0 immediately; after release, re-presented message accepted normally.
6. With AUTH_RX_STATS_EN defined: 300 good messages with rx_ready=1 -> rx_accept_cnt=8'hFF; one bad message -> rx_drop_cnt=8'h01.
